// File: rtl/rca_seq_ctrl.sv
// Multi-cycle N-bit adder: one 4-bit ripple slice reused per nibble, LSB
// nibble first, with a registered carry linking consecutive steps.

// 4-bit ripple-carry slice
module rca_4b (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       ci,
   output logic [3:0] s,
   output logic       co
);

   logic [4:0] c;

   // ripple the carry through the four bit positions
   always_comb begin
      c    = '0;
      s    = '0;
      c[0] = ci;
      for (int unsigned i = 0; i < 4; i++) begin
         s[i]     = a[i] ^ b[i] ^ c[i];
         c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
      end
      co = c[4];
   end

endmodule

module rca_seq_ctrl #(
   parameter int N = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] A,
   input  logic [N-1:0] B,
   input  logic         C_in,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] S,
   output logic         C_out,
   output logic         Ovfl
);

   localparam int STEPS = N / 4;
   localparam int SW    = (STEPS > 1) ? $clog2(STEPS) : 1;
   localparam logic [SW-1:0] LAST = SW'(STEPS - 1);

   generate
      if ((N < 4) || ((N % 4) != 0)) begin : g_bad_n
         $error("rca_seq_ctrl: N must be a multiple of 4 and at least 4");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t        state, state_d;
   logic [SW-1:0] step;
   logic [SW+1:0] base;
   logic [N-1:0]  a_reg, b_reg;
   logic          carry;
   logic [3:0]    nib_sum;
   logic          nib_co;

   assign base = {step, 2'b00};

   rca_4b u_slice (
      .a  (a_reg[base +: 4]),
      .b  (b_reg[base +: 4]),
      .ci (carry),
      .s  (nib_sum),
      .co (nib_co)
   );

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_d;
   end

   // next-state and handshake decode
   always_comb begin
      state_d   = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_d = RUN;
         end
         RUN: begin
            if (step == LAST) state_d = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // operand capture, per-nibble sum write-back and final flags
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_reg <= '0;
         b_reg <= '0;
         carry <= 1'b0;
         step  <= '0;
         S     <= '0;
         C_out <= 1'b0;
         Ovfl  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_reg <= A;
                  b_reg <= B;
                  carry <= C_in;
                  step  <= '0;
               end
            end
            RUN: begin
               S[base +: 4] <= nib_sum;
               carry        <= nib_co;
               step         <= step + 1'b1;
               if (step == LAST) begin
                  C_out <= nib_co;
                  Ovfl  <= (a_reg[N-1] == b_reg[N-1]) && (nib_sum[3] != a_reg[N-1]);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_rca_seq_ctrl.sv
// Directed bench for rca_seq_ctrl (N=16) with hand-computed expectations.
`timescale 1ns/1ps
module tb_rca_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] A, B;
   logic        C_in;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] S;
   logic        C_out;
   logic        Ovfl;

   int n_cmp = 0;
   int n_err = 0;
   int cyc;
   int seen;

   rca_seq_ctrl #(.N(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (A),
      .B         (B),
      .C_in      (C_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .S         (S),
      .C_out     (C_out),
      .Ovfl      (Ovfl)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_cmp++;
      if (obs !== exp_v) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp_v);
      end
   endtask

   // present an operation in IDLE and let the next edge accept it
   task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic c);
      A = a; B = b; C_in = c; in_valid = 1'b1;
      @(posedge clk); #1;
      check("accept_in_ready", {31'd0, in_ready}, 32'd0);
      in_valid = 1'b0;
   endtask

   // edges until out_valid, bounded
   task automatic wait_done(output int n);
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!out_valid && n < 20);
      check("done_timeout", {31'd0, out_valid}, 32'd1);
   endtask

   task automatic check_res(input string tag, input logic [15:0] s, input logic c, input logic o);
      check({tag, "_S"}, {16'd0, S}, {16'd0, s});
      check({tag, "_Cout"}, {31'd0, C_out}, {31'd0, c});
      check({tag, "_Ovfl"}, {31'd0, Ovfl}, {31'd0, o});
   endtask

   task automatic consume(input logic [15:0] s);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("consume_out_valid", {31'd0, out_valid}, 32'd0);
      check("consume_in_ready", {31'd0, in_ready}, 32'd1);
      check("consume_S_hold", {16'd0, S}, {16'd0, s});
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      A = '0; B = '0; C_in = 1'b0;
      #2;
      check("por_in_ready", {31'd0, in_ready}, 32'd1);
      check("por_out_valid", {31'd0, out_valid}, 32'd0);
      check_res("por", 16'h0000, 1'b0, 1'b0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      // asynchronous reset in RUN, after step 0 wrote S[3:0]=3
      start_op(16'h1111, 16'h2222, 1'b0);
      @(posedge clk); #1;
      check("t1_S_partial", {28'd0, S[3:0]}, 32'h3);
      #3 rst = 1'b1;
      #1;
      check("t1_in_ready", {31'd0, in_ready}, 32'd1);
      check("t1_out_valid", {31'd0, out_valid}, 32'd0);
      check_res("t1", 16'h0000, 1'b0, 1'b0);
      #1 rst = 1'b0;
      @(posedge clk); #1;

      // basic add, operands changed after accept must be ignored
      start_op(16'h1234, 16'h4321, 1'b0);
      @(posedge clk); #1;
      A = 16'hFFFF; B = 16'hFFFF; C_in = 1'b1;
      wait_done(cyc);
      check("t2_latency", cyc + 1, 32'd4);
      check_res("t2", 16'h5555, 1'b0, 1'b0);
      consume(16'h5555);

      // full ripple across all nibble boundaries
      start_op(16'hFFFF, 16'h0000, 1'b1);
      wait_done(cyc);
      check("t3_latency", cyc, 32'd4);
      check_res("t3", 16'h0000, 1'b1, 1'b0);
      consume(16'h0000);

      // signed overflow cases
      start_op(16'h7FFF, 16'h0001, 1'b0);
      wait_done(cyc);
      check_res("t4a", 16'h8000, 1'b0, 1'b1);
      consume(16'h8000);
      start_op(16'h8000, 16'h8000, 1'b0);
      wait_done(cyc);
      check_res("t4b", 16'h0000, 1'b1, 1'b1);
      consume(16'h0000);

      // back-to-back with out_ready held high: issue interval
      out_ready = 1'b1;
      start_op(16'h0001, 16'h0002, 1'b0);
      in_valid = 1'b1;
      cyc = 0; seen = 0;
      do begin
         @(posedge clk); #1;
         cyc++;
         if (in_ready) seen = 1;
      end while (!(seen == 1 && !in_ready) && cyc < 20);
      check("t_interval", cyc, 32'd6);
      check("t_interval_S", {16'd0, S}, 32'h0003);
      in_valid = 1'b0;
      out_ready = 1'b0;
      wait_done(cyc);
      check_res("t_b2b", 16'h0003, 1'b0, 1'b0);
      consume(16'h0003);

      // backpressure with a new request waiting
      start_op(16'h0102, 16'h0304, 1'b0);
      wait_done(cyc);
      A = 16'h1111; B = 16'h1111; C_in = 1'b0; in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check_res("t5_hold", 16'h0406, 1'b0, 1'b0);
         check("t5_in_ready", {31'd0, in_ready}, 32'd0);
         check("t5_out_valid", {31'd0, out_valid}, 32'd1);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("t5_idle_in_ready", {31'd0, in_ready}, 32'd1);
      check("t5_idle_out_valid", {31'd0, out_valid}, 32'd0);
      @(posedge clk); #1;
      check("t5_accept", {31'd0, in_ready}, 32'd0);
      in_valid = 1'b0;
      wait_done(cyc);
      check_res("t5_next", 16'h2222, 1'b0, 1'b0);
      consume(16'h2222);

      // reset after two steps: no result for the aborted op
      start_op(16'h0F0F, 16'h0101, 1'b0);
      @(posedge clk); #1;
      @(posedge clk); #3;
      rst = 1'b1;
      #2 rst = 1'b0;
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (out_valid) seen = 1;
      end
      check("t6_no_out_valid", seen, 32'd0);
      start_op(16'h0001, 16'hFFFF, 1'b0);
      wait_done(cyc);
      check("t6_latency", cyc, 32'd4);
      check_res("t6", 16'h0000, 1'b1, 1'b0);
      consume(16'h0000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/rca_seq_ctrl.md
Name: rca_seq_ctrl

Overview:
Multi-cycle N-bit adder controller. It reuses one internal rca_4b slice, one 4-bit nibble per cycle, least-significant nibble first. A registered nibble-carry links the steps.
Uses a valid/ready handshake on both sides. It serves area-constrained datapaths that can tolerate N/4 cycles of latency instead of a full-width ripple-carry adder.

Parameters:
N, 16, operand/result width; must be a multiple of 4 and at least 4; any other value is an illegal configuration.
STEPS, N/4, derived and not overridable; number of slice cycles per operation.

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous active-high reset
in_valid  in  1  operands A, B, C_in present
in_ready  out  1  controller can accept an operation
A  in  N  operand A
B  in  N  operand B
C_in  in  1  carry into bit 0
out_valid  out  1  result S, C_out, Ovfl valid
out_ready  in  1  consumer takes the result
S  out  N  sum A+B+C_in, modulo 2^N
C_out  out  1  carry out of bit N-1
Ovfl  out  1  two's-complement overflow

Behaviour:
- States: IDLE, RUN, DONE. State, step counter, operand registers, carry register and result registers are all flops cleared by rst.
- Reset values, asserted immediately on rst and independent of clk:
  - state=IDLE, in_ready=1, out_valid=0.
  - S=0, C_out=0, Ovfl=0, step counter=0.
- in_ready=1 only in IDLE; out_valid=1 only in DONE. Both are decoded from state.
- IDLE:
  - On the edge where in_valid&in_ready (accept edge E0), capture A, B and C_in into internal registers, set step=0 and go to RUN.
  - After E0, changes on A, B, C_in and in_valid are ignored until the controller returns to IDLE.
- RUN, step k in 0..STEPS-1:
  - The slice adds A_reg[4k+3:4k] + B_reg[4k+3:4k] + carry_reg.
  - At the clock edge, the 4-bit sum is written into S[4k+3:4k], carry_reg takes the slice carry-out and step increments.
  - On step STEPS-1, the same edge also loads C_out from the slice carry-out, loads Ovfl = (A_reg[N-1]==B_reg[N-1]) && (sum[N-1]!=A_reg[N-1]), and moves the state to DONE.
- Latency: out_valid rises after edge E0+STEPS (4 cycles for N=16). For N=4, DONE follows E0+1.
- S bits above the active slice hold stale data during RUN. S, C_out and Ovfl are only meaningful while out_valid=1.
- DONE:
  - S, C_out and Ovfl hold stable for as long as the state remains DONE.
  - On an edge where out_ready=1, go to IDLE. Outputs keep their values; out_valid drops.
  - No new operation is accepted in the same cycle, so minimum issue interval is STEPS+2 cycles.
- in_valid arriving during RUN or DONE is not accepted; the requester must hold it until in_ready=1.
- out_ready while not in DONE has no effect.
- rst asserted mid-operation, in RUN or DONE, aborts the operation:
  - Go to IDLE with reset values.
  - No out_valid pulse is produced for the aborted operation.
  - The first operation after rst deasserts computes correctly.
- Arithmetic: unsigned modulo-2^N sum, carry chained exactly through the nibble boundaries. The result is bit-identical to a combinational N-bit A+B+C_in.

Test Plan:
1. Assert rst between clock edges while in RUN -> in_ready=1, out_valid=0, S=0, C_out=0 and Ovfl=0 immediately, before the next edge.
2. Issue A=16'h1234, B=16'h4321, C_in=0, then drive A=16'hFFFF one cycle after accept -> out_valid high exactly 4 cycles after accept; S=16'h5555, C_out=0, Ovfl=0.
3. Full ripple: A=16'hFFFF, B=16'h0000, C_in=1 -> S=16'h0000, C_out=1, Ovfl=0; the carry crosses all three nibble boundaries.
4. Signed overflow:
   - A=16'h7FFF, B=16'h0001, C_in=0 -> S=16'h8000, C_out=0, Ovfl=1.
   - A=16'h8000, B=16'h8000, C_in=0 -> S=16'h0000, C_out=1, Ovfl=1.
5. Backpressure: hold out_ready=0 for 5 cycles after out_valid while in_valid=1 with new operands -> S/C_out/Ovfl stable and in_ready=0 throughout. Raise out_ready -> IDLE on the next edge, new operands accepted on the edge after that, issue interval 6 cycles.
6. Reset after step 2 of A=16'h0F0F, B=16'h0101 -> no out_valid for that operation. The next operation, A=16'h0001, B=16'hFFFF, C_in=0, gives S=16'h0000, C_out=1, Ovfl=0.
